// File: rtl/ksa_swap.sv
// RC4 key-scheduling engine: permutes the 256-byte S-memory using a 3-byte key.
// Drives the KSA port of the S-memory mux and reports completion through a level start/done handshake.
module ksa_swap (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] key,
    input  logic [7:0]  q,
    output logic [7:0]  address,
    output logic [7:0]  data,
    output logic        rden,
    output logic        wren,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT_I,
        S_RD_J,
        S_WAIT_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [1:0]  kidx;
    logic [7:0]  key_byte;

    // kidx tracks i mod 3 so no divider is needed on i
    always_comb begin
        case (kidx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_RD_I;
            S_RD_I:   state_nx = S_WAIT_I;
            S_WAIT_I: state_nx = S_RD_J;
            S_RD_J:   state_nx = S_WAIT_J;
            S_WAIT_J: state_nx = S_WR_I;
            S_WR_I:   state_nx = S_WR_J;
            S_WR_J:   state_nx = (i == 8'hFF) ? S_DONE : S_RD_I;
            S_DONE:   if (!start) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i    <= '0;
            j    <= '0;
            si   <= '0;
            sj   <= '0;
            kidx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    i    <= '0;
                    j    <= '0;
                    kidx <= '0;
                end
                S_WAIT_I: begin
                    si <= q;
                    j  <= j + q + key_byte;
                end
                S_WAIT_J: begin
                    sj <= q;
                end
                S_WR_J: begin
                    // i stops at 255 so the loop cannot wrap and restart
                    if (i != 8'hFF) begin
                        i    <= i + 8'd1;
                        kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        i    <= '0;
                        j    <= '0;
                        kidx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        address = '0;
        data    = '0;
        rden    = 1'b0;
        wren    = 1'b0;
        done    = 1'b0;
        case (state)
            S_RD_I, S_WAIT_I: begin
                address = i;
                rden    = 1'b1;
            end
            S_RD_J, S_WAIT_J: begin
                address = j;
                rden    = 1'b1;
            end
            S_WR_I: begin
                address = i;
                data    = sj;
                wren    = 1'b1;
            end
            S_WR_J: begin
                address = j;
                data    = si;
                wren    = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ksa_swap.md
# ksa_swap

Key-scheduling (KSA) engine of the RC4 decoder. After the S-memory has been initialised to s[k]=k, it permutes the 256-byte S array using the 24-bit secret key. It drives the phase-1 (KSA) input of the S-memory arbitration mux and consumes the memory's read data. It is started and monitored by the top-level phase controller through a level start/done handshake.

## Interface
- No parameters: key length fixed at 3 bytes, S size fixed at 256.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request from phase controller; sampled only in IDLE
- key  in  24  secret key; key[23:16] used when i mod 3 = 0, key[15:8] when i mod 3 = 1, key[7:0] when i mod 3 = 2; held stable while busy
- q  in  8  S-memory read data
- address  out  8  S-memory address
- data  out  8  S-memory write data
- rden  out  1  S-memory read enable
- wren  out  1  S-memory write enable
- done  out  1  high in DONE state

## Operation
- Algorithm: j=0; for i=0..255 { j = j + s[i] + key[i mod 3]; swap s[i], s[j] }.
- Registers: i[7:0], j[7:0], si[7:0], sj[7:0], state.
- All index arithmetic is 8-bit modulo 256; carries are dropped.
- States and transitions:
  - IDLE: i=0, j=0. Goes to RD_I when start=1.
  - RD_I: address=i, rden=1. Goes to WAIT_I.
  - WAIT_I: address=i, rden=1. At the clock edge, si<=q and j<=j+q+keybyte(i). Goes to RD_J.
  - RD_J: address=j (updated value), rden=1. Goes to WAIT_J.
  - WAIT_J: address=j, rden=1. At the clock edge, sj<=q. Goes to WR_I.
  - WR_I: address=i, data=sj, wren=1. Goes to WR_J.
  - WR_J: address=j, data=si, wren=1. If i=255, goes to DONE. Otherwise i<=i+1 and goes to RD_I.
  - DONE: done=1. Stays in DONE while start=1. Returns to IDLE when start=0; i and j are cleared.
- Termination test is i=255 in WR_J, before any increment, so i never wraps to 0 and restarts the loop.
- When not accessing memory: address=0, data=0, rden=0, wren=0. rden and wren are never high together.
- keybyte(i) is selected by a 2-bit mod-3 counter that tracks i. The counter resets to 0 with i and wraps 2→0.

## Timing
- Memory model: the RAM has registered inputs and one-cycle read latency. An address presented with rden in cycle N yields q valid in cycle N+1; q is sampled at the end of cycle N+1, which is why the WAIT states exist.
- Writes take effect at the edge ending the write cycle.
- Each iteration takes 6 cycles; a full run takes 1536 cycles.
- done rises 1536 rising edges after the edge that samples start=1 in IDLE.
- Outputs are registered-state decodes with no combinational path from start or q to outputs.
- Reset values (asynchronous, rst_n=0): state=IDLE, i=0, j=0, si=0, sj=0, address=0, data=0, rden=0, wren=0, done=0.
- Boundary conditions:
  - i=j: both reads return the same byte; WR_I and WR_J write that same byte, so S is unchanged. No special-casing.
  - start dropped mid-run: ignored; the run completes. done is then high for exactly one cycle (DONE→IDLE).
  - start held high after DONE: done stays high; no restart until start has been seen low in IDLE.
  - Reset mid-run: immediate abort to IDLE with all outputs 0. The S-memory is left partially permuted; the phase controller must rerun initialisation.
  - key change mid-run: undefined result. The key is not registered.

## Test plan
- Reset during RD_J at iteration 10 → address, data, rden, wren and done all 0 asynchronously. Restart from IDLE with S reinitialised gives the correct final S.
- S initialised to s[k]=k, key=0x010203 → first writes are addr 0←1 then addr 1←0 (j=1). Second iteration writes addr 1←3 then addr 3←0 (j=3).
- Full run with key=0x000000 and with key=0x035F3C → final 256-byte S matches the software RC4 KSA model byte-for-byte. done rises exactly 1536 edges after start is sampled.
- Iteration with i=j (key=0x000000, i=0: s[0]=0, j=0) → two writes to addr 0 with data 0; S unchanged.
- start pulsed high for 1 cycle → run completes, done high exactly 1 cycle, return to IDLE. start held high → done stays high, and a second run does not begin until start toggles low then high.
- Protocol check over the full run → rden and wren never both high; each WAIT state presents the same address as its preceding RD state; no memory access in IDLE or DONE.
